// File: rtl/tt_bus_pkg.sv
// tt_bus_pkg: shared phase constants, FSM state encoding and phase-step helper
// for the tt_bus_target byte-handshake bus target.
package tt_bus_pkg;

  localparam logic [1:0] PH_ADDR_LO = 2'd0;
  localparam logic [1:0] PH_ADDR_HI = 2'd1;
  localparam logic [1:0] PH_DATA    = 2'd2;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_MEM  = 2'd1,
    S_ACK  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  // ADDR_LO -> ADDR_HI -> DATA -> ADDR_LO; the unused code 3 also returns to ADDR_LO.
  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    case (ph)
      PH_ADDR_LO: next_phase = PH_ADDR_HI;
      PH_ADDR_HI: next_phase = PH_DATA;
      default:    next_phase = PH_ADDR_LO;
    endcase
  endfunction

endpackage

// File: rtl/tt_bus_sync.sv
// tt_bus_sync: W-bit two-flop synchroniser, asynchronous active-low reset to 0.
// Used by tt_bus_target only when TT_BUS_SYNC_EN is defined.
module tt_bus_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two back-to-back flops give metastability settling time before use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/tt_bus_target.sv
// tt_bus_target: target side of the 8080 core strobe/ack byte bus.
// Collects address-low, address-high and data bytes, performs one req/ready
// memory access per transfer and drives read data back on the shared bus.
// Optional build macro TT_BUS_SYNC_EN: when defined, strobe_in/rd_in/wr_in go
// through a 2-flop synchroniser (adds 2 cycles of latency to all three alike).
module tt_bus_target
  import tt_bus_pkg::*;
#(
  parameter int ACK_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strobe_in,
  input  logic        rd_in,
  input  logic        wr_in,
  output logic        ack_out,
  input  logic [7:0]  bus_in,
  output logic [7:0]  bus_out,
  output logic        bus_oe,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready
);

  localparam logic [2:0] HOLD_INIT = 3'(ACK_HOLD);

  logic strb;
  logic rd;
  logic wr;

`ifdef TT_BUS_SYNC_EN
  logic [2:0] sync_out;

  tt_bus_sync #(.W(3)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({strobe_in, rd_in, wr_in}),
    .q     (sync_out)
  );

  assign {strb, rd, wr} = sync_out;
`else
  assign strb = strobe_in;
  assign rd   = rd_in;
  assign wr   = wr_in;
`endif

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        req_q, req_d;
  logic        oe_q, oe_d;
  logic [7:0]  bus_out_q, bus_out_d;
  logic [1:0]  ph;

  // Next-state, byte capture and registered-output decode.
  always_comb begin
    ph        = (phase_q == 2'd3) ? PH_ADDR_LO : phase_q;
    state_d   = state_q;
    phase_d   = ph;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      S_WAIT: begin
        // Core idle mid-sequence (or reset on its side): realign to ADDR_LO.
        if (phase_q != PH_ADDR_LO && !rd && !wr) begin
          phase_d = PH_ADDR_LO;
        end else if (strb) begin
          case (ph)
            PH_ADDR_LO: begin
              addr_d[7:0] = bus_in;
              state_d     = S_ACK;
            end
            PH_ADDR_HI: begin
              addr_d[15:8] = bus_in;
              state_d      = S_ACK;
            end
            default: begin
              // wr wins when both status lines are high.
              we_d = wr;
              if (wr) wdata_d = bus_in;
              state_d = S_MEM;
            end
          endcase
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!strb) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_INIT;
        end
      end
      S_HOLD: begin
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          state_d = S_WAIT;
          phase_d = next_phase(ph);
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    ack_d     = (state_d == S_ACK) || (state_d == S_HOLD);
    req_d     = (state_d == S_MEM);
    oe_d      = ack_d && (phase_d == PH_DATA) && !we_d;
    bus_out_d = oe_d ? rdata_d : 8'h00;
  end

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_WAIT;
      phase_q   <= PH_ADDR_LO;
      cnt_q     <= 3'd0;
      addr_q    <= 16'h0000;
      we_q      <= 1'b0;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      ack_q     <= 1'b0;
      req_q     <= 1'b0;
      oe_q      <= 1'b0;
      bus_out_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      req_q     <= req_d;
      oe_q      <= oe_d;
      bus_out_q <= bus_out_d;
    end
  end

  assign ack_out   = ack_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign bus_oe    = oe_q;
  assign bus_out   = bus_out_q;

endmodule

// File: tb/tb_tt_bus_target.sv
// tb_tt_bus_target: directed stimulus with scoreboard queues for memory
// accesses and read-data bus drives, checked by independent monitors.
module tb_tt_bus_target;

`ifdef TT_BUS_SYNC_EN
  localparam int AH  = 3;
  localparam int LAT = 2;
`else
  localparam int AH  = 1;
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strobe_in = 1'b0;
  logic        rd_in = 1'b0;
  logic        wr_in = 1'b0;
  logic [7:0]  bus_in = 8'h00;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ready = 1'b0;
  logic        ack_out;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;

  tt_bus_target #(.ACK_HOLD(AH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strobe_in (strobe_in),
    .rd_in     (rd_in),
    .wr_in     (wr_in),
    .ack_out   (ack_out),
    .bus_in    (bus_in),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } acc_t;

  acc_t       exp_q[$];
  logic [7:0] rd_q[$];
  int errors = 0;
  int checks = 0;
  int req_cnt = 0;
  int overlap = 0;
  int mem_delay = 0;
  logic [7:0] rd_value = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: answers each request after mem_delay idle cycles.
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_req && rst_n) begin
        if (wait_cnt >= mem_delay) begin
          mem_ready = 1'b1;
          mem_rdata = rd_value;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: compares each new memory access and each new bus drive.
  initial begin : monitor
    logic prev_req, prev_oe;
    acc_t e;
    logic [7:0] r;
    prev_req = 1'b0;
    prev_oe  = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && ack_out) overlap++;
      if (mem_req && !prev_req) begin
        req_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected mem_req addr", {16'h0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("mem_addr", {16'h0, mem_addr}, {16'h0, e.addr});
          check("mem_we", {31'h0, mem_we}, {31'h0, e.we});
          if (e.we) check("mem_wdata", {24'h0, mem_wdata}, {24'h0, e.wdata});
        end
      end
      if (bus_oe && !prev_oe) begin
        if (rd_q.size() == 0) begin
          check("unexpected bus_oe data", {24'h0, bus_out}, 32'hFFFF_FFFF);
        end else begin
          r = rd_q.pop_front();
          check("bus_out read data", {24'h0, bus_out}, {24'h0, r});
        end
      end
      prev_req = mem_req;
      prev_oe  = bus_oe;
    end
  end

  // One strobe/ack byte exchange with latency, hold and bus-drive checks.
  task automatic send_byte(input logic [7:0] b, input logic r, input logic w,
                           input logic drv, input logic [7:0] drv_val,
                           input int exp_lat, input string tag);
    int n, h;
    logic bad;
    bad = 1'b0;
    @(negedge clk);
    bus_in = b; rd_in = r; wr_in = w; strobe_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus_oe !== (drv && ack_out)) bad = 1'b1;
      if (bus_out !== ((drv && ack_out) ? drv_val : 8'h00)) bad = 1'b1;
    end while (!ack_out && n < 200);
    check({tag, " ack latency"}, n, exp_lat);
    strobe_in = 1'b0;
    bus_in = 8'h00;
    h = 0;
    @(negedge clk);
    if (bus_oe !== (drv && ack_out)) bad = 1'b1;
    if (bus_out !== ((drv && ack_out) ? drv_val : 8'h00)) bad = 1'b1;
    while (ack_out && h < 200) begin
      h++;
      @(negedge clk);
      if (bus_oe !== (drv && ack_out)) bad = 1'b1;
      if (bus_out !== ((drv && ack_out) ? drv_val : 8'h00)) bad = 1'b1;
    end
    check({tag, " ack hold"}, h, AH + LAT);
    check({tag, " bus drive window"}, {31'h0, bad}, 32'h0);
  endtask

  task automatic xfer(input logic [15:0] addr, input logic [7:0] data, input logic write,
                      input int delay, input string tag);
    mem_delay = delay;
    rd_value  = write ? 8'h00 : data;
    send_byte(addr[7:0], !write, write, 1'b0, 8'h00, 1 + LAT, {tag, " lo"});
    send_byte(addr[15:8], !write, write, 1'b0, 8'h00, 1 + LAT, {tag, " hi"});
    exp_q.push_back('{addr: addr, we: write, wdata: data});
    if (!write) rd_q.push_back(data);
    send_byte(data, !write, write, !write, data, 2 + delay + LAT, {tag, " data"});
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rd_in = 1'b0; wr_in = 1'b0; strobe_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base, n;
    repeat (3) @(negedge clk);
    check("reset ack_out",   {31'h0, ack_out},   32'h0);
    check("reset bus_oe",    {31'h0, bus_oe},    32'h0);
    check("reset bus_out",   {24'h0, bus_out},   32'h0);
    check("reset mem_req",   {31'h0, mem_req},   32'h0);
    check("reset mem_we",    {31'h0, mem_we},    32'h0);
    check("reset mem_addr",  {16'h0, mem_addr},  32'h0);
    check("reset mem_wdata", {24'h0, mem_wdata}, 32'h0);
    rst_n = 1'b1;

    // Plain write of 0xA5 to 0x1234.
    xfer(16'h1234, 8'hA5, 1'b1, 0, "wr1234");
    idle(3);

    // Read of 0x0100 with a slow memory.
    xfer(16'h0100, 8'h5C, 1'b0, 5, "rd0100");
    idle(3);

    // Back-to-back fetch then write with no idle gap.
    base = req_cnt;
    xfer(16'h0300, 8'hC3, 1'b0, 1, "fetch0300");
    xfer(16'h0400, 8'h4D, 1'b1, 0, "wr0400");
    idle(3);
    check("back-to-back req count", req_cnt - base, 2);

    // Reset while the write is waiting in the memory stage.
    mem_delay = 30;
    send_byte(8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1 + LAT, "abort lo");
    send_byte(8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 1 + LAT, "abort hi");
    exp_q.push_back('{addr: 16'h2211, we: 1'b1, wdata: 8'h33});
    @(negedge clk);
    bus_in = 8'h33; wr_in = 1'b1; strobe_in = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_req && n < 200);
    check("abort reached mem stage", {31'h0, mem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("abort ack_out",   {31'h0, ack_out},   32'h0);
    check("abort bus_oe",    {31'h0, bus_oe},    32'h0);
    check("abort bus_out",   {24'h0, bus_out},   32'h0);
    check("abort mem_req",   {31'h0, mem_req},   32'h0);
    check("abort mem_we",    {31'h0, mem_we},    32'h0);
    check("abort mem_addr",  {16'h0, mem_addr},  32'h0);
    check("abort mem_wdata", {24'h0, mem_wdata}, 32'h0);
    @(negedge clk);
    strobe_in = 1'b0; wr_in = 1'b0; rd_in = 1'b0; bus_in = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = req_cnt;
    repeat (6) @(negedge clk);
    check("no req after reset", req_cnt - base, 0);
    xfer(16'hBEEF, 8'h01, 1'b1, 0, "wrBEEF");
    idle(3);
    check("one req after reset", req_cnt - base, 1);

    // Lone address-low byte, core goes idle, then a full read.
    send_byte(8'h77, 1'b1, 1'b0, 1'b0, 8'h00, 1 + LAT, "resync lo");
    idle(4);
    xfer(16'h2000, 8'h9E, 1'b0, 2, "rd2000");
    idle(4);

    check("access queue drained", exp_q.size(), 0);
    check("read queue drained", rd_q.size(), 0);
    check("mem_req/ack overlap cycles", overlap, 0);
    check("total mem_req pulses", req_cnt, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
